// File: rtl/fht_pkg.sv
// Shared definitions for the FHT bank write-back stage: state encoding,
// default widths and saturation bounds derived from the data width.
package fht_pkg;

   localparam int D_BIT_DEF  = 17;
   localparam int A_BIT_DEF  = 8;
   localparam int ST_BIT_DEF = 4;
   localparam int ST_NUM_DEF = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fht_state_t;

   // Largest value representable in a d-bit two's complement word.
   function automatic longint sat_max(input int d);
      return (longint'(1) <<< (d - 1)) - longint'(1);
   endfunction

   // Smallest value representable in a d-bit two's complement word.
   function automatic longint sat_min(input int d);
      return -(longint'(1) <<< (d - 1));
   endfunction

endpackage

// File: rtl/fht_scale_sat.sv
// One lane of optional halving: pass-through, or (x + 1) >>> 1 with the
// rounding increment checked against the word range before the shift.
// Only the increment of the maximum positive word leaves the range; that
// case clamps to the maximum and raises the overflow flag.
module fht_scale_sat
   import fht_pkg::*;
#(
   parameter int D_BIT = D_BIT_DEF
) (
   input  logic                    i_scale,
   input  logic signed [D_BIT-1:0] i_x,
   output logic signed [D_BIT-1:0] o_y,
   output logic                    o_ovf
);

   localparam logic signed [D_BIT:0] MAX_V = (D_BIT+1)'(sat_max(D_BIT));
   localparam logic signed [D_BIT:0] MIN_V = (D_BIT+1)'(sat_min(D_BIT));

   logic signed [D_BIT:0] w_inc;

   // Rounding increment, sign-extended by one bit so it cannot wrap.
   assign w_inc = {i_x[D_BIT-1], i_x} + (D_BIT+1)'(1);

   // Select pass-through, clamped or halved result for this lane.
   always_comb begin
      o_y   = i_x;
      o_ovf = 1'b0;
      if (i_scale) begin
         if (w_inc > MAX_V) begin
            o_y   = MAX_V[D_BIT-1:0];
            o_ovf = 1'b1;
         end else if (w_inc < MIN_V) begin
            o_y   = MIN_V[D_BIT-1:0];
            o_ovf = 1'b1;
         end else begin
            o_y   = w_inc[D_BIT:1];
         end
      end
   end

endmodule

// File: rtl/fht_bank_wr.sv
// Write-back stage behind the double butterfly. Every accepted beat becomes
// one registered write to all four banks at the current beat address; beat
// and stage counters track stage and transform completion.
//
// Handshake: there is no back-pressure. A beat is taken on any rising edge
// with iVALID=1 while the FSM is in RUN; iVALID outside RUN drops the beat
// and sets the sticky error flag (an iSTART accepted on the same edge wins
// and leaves the flag clear).
module fht_bank_wr
   import fht_pkg::*;
#(
   parameter int D_BIT  = D_BIT_DEF,
   parameter int A_BIT  = A_BIT_DEF,
   parameter int ST_BIT = ST_BIT_DEF,
   parameter int ST_NUM = ST_NUM_DEF
) (
   input  logic                    iCLK,
   input  logic                    iRESET,
   input  logic                    iSTART,
   input  logic                    iVALID,
   input  logic                    iSCALE,
   input  logic signed [D_BIT-1:0] iY_0,
   input  logic signed [D_BIT-1:0] iY_1,
   input  logic signed [D_BIT-1:0] iY_2,
   input  logic signed [D_BIT-1:0] iY_3,
   output logic                    oWR_EN,
   output logic [A_BIT-1:0]        oWR_ADDR,
   output logic signed [D_BIT-1:0] oWR_0,
   output logic signed [D_BIT-1:0] oWR_1,
   output logic signed [D_BIT-1:0] oWR_2,
   output logic signed [D_BIT-1:0] oWR_3,
   output logic [ST_BIT-1:0]       oSTAGE,
   output logic                    oST_LAST,
   output logic                    oST_DONE,
   output logic                    oFHT_DONE,
   output logic                    oBUSY,
   output logic                    oOVF,
   output logic                    oERR,
   output fht_state_t              oDBG_STATE
);

   localparam logic [ST_BIT-1:0] STAGE_LAST = ST_BIT'(ST_NUM - 1);

   fht_state_t r_state;
   fht_state_t w_state_nxt;

   logic [A_BIT-1:0]        r_beat;
   logic [ST_BIT-1:0]       r_stage;
   logic [ST_BIT-1:0]       r_stage_q;
   logic                    r_wr_en;
   logic [A_BIT-1:0]        r_wr_addr;
   logic signed [D_BIT-1:0] r_wr [4];
   logic                    r_st_done;
   logic                    r_fht_done;
   logic                    r_ovf;
   logic                    r_err;

   logic signed [D_BIT-1:0] w_y_in [4];
   logic signed [D_BIT-1:0] w_y_sc [4];
   logic [3:0]              w_lane_ovf;
   logic                    w_start;
   logic                    w_beat;
   logic                    w_stray;
   logic                    w_beat_wrap;
   logic                    w_stage_last;
   logic                    w_last_write;

   assign w_y_in[0] = iY_0;
   assign w_y_in[1] = iY_1;
   assign w_y_in[2] = iY_2;
   assign w_y_in[3] = iY_3;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      fht_scale_sat #(
         .D_BIT (D_BIT)
      ) u_scale_sat (
         .i_scale (iSCALE),
         .i_x     (w_y_in[g]),
         .o_y     (w_y_sc[g]),
         .o_ovf   (w_lane_ovf[g])
      );
   end

   assign w_start      = (r_state == ST_IDLE) && iSTART;
   assign w_beat       = (r_state == ST_RUN) && iVALID;
   assign w_stray      = (r_state != ST_RUN) && iVALID;
   assign w_beat_wrap  = (r_beat == {A_BIT{1'b1}});
   assign w_stage_last = (r_stage == STAGE_LAST);
   assign w_last_write = w_beat && w_beat_wrap && w_stage_last;

   // Next state: start from idle, finish on the last beat of the last stage,
   // spend exactly one cycle in DONE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (iSTART) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last_write) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge iCLK) begin
      if (iRESET) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Beat/stage counters and sticky flags; the displayed stage lags the
   // counter so it changes the cycle after the stage-done pulse.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         r_beat    <= '0;
         r_stage   <= '0;
         r_stage_q <= '0;
         r_ovf     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_stage_q <= r_stage;
         if (w_beat) begin
            r_beat <= r_beat + 1'b1;
            if (w_beat_wrap && !w_stage_last) r_stage <= r_stage + 1'b1;
            if (iSCALE && (|w_lane_ovf)) r_ovf <= 1'b1;
         end
         if (w_start) begin
            r_beat    <= '0;
            r_stage   <= '0;
            r_stage_q <= '0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
         end else if (w_stray) begin
            r_err <= 1'b1;
         end
      end
   end

   // Write port: strobes pulse for one cycle, address/data hold between beats.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_st_done  <= 1'b0;
         r_fht_done <= 1'b0;
         for (int i = 0; i < 4; i++) r_wr[i] <= '0;
      end else begin
         r_wr_en    <= w_beat;
         r_st_done  <= w_beat && w_beat_wrap;
         r_fht_done <= w_last_write;
         if (w_beat) begin
            r_wr_addr <= r_beat;
            for (int i = 0; i < 4; i++) r_wr[i] <= w_y_sc[i];
         end
      end
   end

   assign oWR_EN     = r_wr_en;
   assign oWR_ADDR   = r_wr_addr;
   assign oWR_0      = r_wr[0];
   assign oWR_1      = r_wr[1];
   assign oWR_2      = r_wr[2];
   assign oWR_3      = r_wr[3];
   assign oSTAGE     = r_stage_q;
   assign oST_LAST   = (r_stage_q == STAGE_LAST);
   assign oST_DONE   = r_st_done;
   assign oFHT_DONE  = r_fht_done;
   assign oBUSY      = (r_state != ST_IDLE);
   assign oOVF       = r_ovf;
   assign oERR       = r_err;
   assign oDBG_STATE = r_state;

endmodule

// File: doc/fht_bank_wr.md
# fht_bank_wr

Write-back stage directly downstream of the double-butterfly block. Takes the four registered butterfly results per beat, applies optional per-stage halving with rounding and saturation, generates bank write addresses and write enables for the four data RAM banks, and tracks stage and transform completion. It closes the read → mix → butterfly → write loop for each FHT stage.

## Interface
- D_BIT, 17, signed data width of butterfly results and bank words
- A_BIT, 8, bank address width; each bank holds 2^A_BIT words, beats per stage = 2^A_BIT
- ST_BIT, 4, stage counter width
- ST_NUM, 10, number of stages per transform (1..2^ST_BIT-1)
- iCLK  in  1  clock, all logic on rising edge
- iRESET  in  1  reset, synchronous, active-high
- iSTART  in  1  one-cycle pulse, starts a transform when idle
- iVALID  in  1  iY_0..iY_3 carry a valid beat this cycle
- iSCALE  in  1  sampled per beat; 1 = halve results of this beat
- iY_0..iY_3  in  D_BIT each  signed butterfly outputs, bank 0..3 order
- oWR_EN  out  1  write strobe, common to all four banks
- oWR_ADDR  out  A_BIT  write address, common to all four banks
- oWR_0..oWR_3  out  D_BIT each  signed write data for banks 0..3
- oSTAGE  out  ST_BIT  index of stage currently being written
- oST_LAST  out  1  high while oSTAGE == ST_NUM-1
- oST_DONE  out  1  one-cycle pulse after last write of a stage
- oFHT_DONE  out  1  one-cycle pulse after last write of last stage
- oBUSY  out  1  high from accepted iSTART until oFHT_DONE cycle inclusive
- oOVF  out  1  sticky: saturation occurred since last iSTART
- oERR  out  1  sticky: iVALID received while idle since last iSTART

## Operation
- FSM states IDLE, RUN, DONE. Reset → IDLE.
- IDLE: iSTART → RUN, clear beat counter, stage counter, oOVF, oERR. iVALID in IDLE: beat dropped, oERR set (iSTART same cycle takes precedence: beat dropped, oERR stays cleared).
- RUN: each iVALID beat produces one write; beat counter increments; wraps 2^A_BIT-1 → 0 with oST_DONE pulse and stage increment. Wrap on stage ST_NUM-1 → DONE. iSTART in RUN ignored.
- DONE: one cycle, oFHT_DONE=1, → IDLE. iVALID in DONE treated as in IDLE.
- Address: oWR_ADDR = beat counter value of the beat being written. No bit-reversal; reordering is upstream's job.
- Scaling, per lane: iSCALE=0 → pass through. iSCALE=1 → (x + 1) >>> 1 computed at D_BIT+1 bits, round half up; saturate to [-(2^(D_BIT-1)), 2^(D_BIT-1)-1]; any lane saturating sets oOVF. Only the +1 rounding of max positive can overflow; pass-through never sets oOVF.
- Gaps in iVALID are allowed anywhere; counters hold.

## Timing
- Latency 1: beat at edge n appears on oWR_* with oWR_EN=1 after edge n+1; oWR_EN low otherwise, oWR_* hold last value.
- oST_DONE and oFHT_DONE asserted in the same cycle as the final write of that stage/transform; oSTAGE updates the following cycle.
- oBUSY falls the cycle after the oFHT_DONE cycle.
- Reset values: oWR_EN 0, oWR_ADDR 0, oWR_0..3 0, oSTAGE 0, oST_LAST (ST_NUM==1), oST_DONE 0, oFHT_DONE 0, oBUSY 0, oOVF 0, oERR 0.
- Reset mid-transform: next edge returns everything to reset values; the in-flight beat is not written.

## Structure
- Shared package fht_pkg: state encoding (IDLE/RUN/DONE), default D_BIT/A_BIT/ST_BIT, saturation bounds as functions of D_BIT.
- One sub-module natural: fht_scale_sat (one lane: round, halve, saturate, overflow flag), instantiated four times.

## Test plan
- A_BIT=2, ST_NUM=2, iSTART then 8 consecutive valid beats, iSCALE=0 → addresses 0,1,2,3,0,1,2,3; oST_DONE on 4th write; oFHT_DONE on 8th; oBUSY low 1 cycle later.
- iSCALE=1, lanes 5, -5, 2^(D_BIT-1)-1, -1 → 3, -2, 2^(D_BIT-1)-1 with oOVF=1, 0.
- Valid beats with 3-cycle gaps → addresses consecutive, oWR_EN only one cycle after each beat, no extra oST_DONE.
- iVALID while idle → no write, oERR=1; next iSTART clears oERR and oOVF.
- iRESET asserted at beat 2 of stage 1 → outputs at reset values next cycle; fresh iSTART completes a full transform normally.
- iSTART during RUN → ignored; counters and oSTAGE unchanged.
